// File: rtl/idma_legalizer_r_obi_w_txrx.sv
// Legalizer splitting 1D transfers into bus-word chunks for an OBI read port and a TXRX write port.
// Optional macro IDMA_LEGALIZER_OBI_RBE_EN narrows r_be_o to the bytes of the current read chunk.
module idma_legalizer_r_obi_w_txrx #(
  parameter bit          CombinedShifter = 1'b0,
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned AddrWidth       = 32,
  localparam int unsigned StrbWidth      = DataWidth / 8,
  localparam int unsigned OffsetWidth    = (StrbWidth > 1) ? $clog2(StrbWidth) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   req_length_i,
  input  logic [AddrWidth-1:0]   req_src_addr_i,
  input  logic [AddrWidth-1:0]   req_dst_addr_i,
  input  logic                   req_last_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [AddrWidth-1:0]   r_addr_o,
  output logic [StrbWidth-1:0]   r_be_o,
  output logic [OffsetWidth-1:0] r_offset_o,
  output logic [OffsetWidth-1:0] r_tailer_o,
  output logic [OffsetWidth-1:0] r_shift_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [OffsetWidth-1:0] w_offset_o,
  output logic [OffsetWidth-1:0] w_tailer_o,
  output logic [OffsetWidth-1:0] w_shift_o,
  output logic                   w_last_o,
  output logic                   w_super_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  input  logic                   flush_i,
  input  logic                   kill_i,
  output logic                   r_busy_o,
  output logic                   w_busy_o
);

  localparam logic [AddrWidth-1:0] StrbLen = AddrWidth'(StrbWidth);

  // Largest chunk from addr that stays inside one bus word.
  function automatic logic [AddrWidth-1:0] chunk_len(input logic [AddrWidth-1:0] addr,
                                                     input logic [AddrWidth-1:0] len);
    logic [AddrWidth-1:0] room;
    room = StrbLen - AddrWidth'(addr[OffsetWidth-1:0]);
    return (len < room) ? len : room;
  endfunction

`ifdef IDMA_LEGALIZER_OBI_RBE_EN
  function automatic logic [StrbWidth-1:0] be_mask(input logic [OffsetWidth-1:0] off,
                                                   input logic [AddrWidth-1:0]   chunk);
    logic [StrbWidth-1:0] be;
    for (int i = 0; i < StrbWidth; i++) begin
      be[i] = (i >= int'(off)) && (i < int'(off) + int'(chunk));
    end
    return be;
  endfunction
`endif

  logic                   r_vld_p0, w_vld_p0;
  logic [AddrWidth-1:0]   r_addr_p0, r_len_p0, w_addr_p0, w_len_p0;
  logic [OffsetWidth-1:0] r_shift_p0, w_shift_p0;
  logic                   super_last_p0;

  logic [AddrWidth-1:0]   r_chunk, w_chunk;
  logic [OffsetWidth-1:0] r_off, w_off, src_off, dst_off;
  logic                   r_last, w_last, r_fire, w_fire, accept;

  assign r_chunk = chunk_len(r_addr_p0, r_len_p0);
  assign w_chunk = chunk_len(w_addr_p0, w_len_p0);
  assign r_off   = r_addr_p0[OffsetWidth-1:0];
  assign w_off   = w_addr_p0[OffsetWidth-1:0];
  assign src_off = req_src_addr_i[OffsetWidth-1:0];
  assign dst_off = req_dst_addr_i[OffsetWidth-1:0];
  assign r_last  = (r_chunk == r_len_p0);
  assign w_last  = (w_chunk == w_len_p0);

  assign r_valid_o = r_vld_p0 & ~flush_i;
  assign w_valid_o = w_vld_p0 & ~flush_i;
  assign r_fire    = r_valid_o & r_ready_i;
  assign w_fire    = w_valid_o & w_ready_i;

  // A new request may load as soon as both machines drain their final chunk.
  assign ready_o = ~flush_i & ~kill_i
                 & (~r_vld_p0 | (r_fire & r_last))
                 & (~w_vld_p0 | (w_fire & w_last));
  assign accept  = valid_i & ready_o;

  assign r_addr_o       = {r_addr_p0[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}};
  assign r_offset_o     = r_off;
  assign r_tailer_o     = r_off + r_chunk[OffsetWidth-1:0];
  assign r_shift_o      = r_shift_p0;
  assign w_offset_o     = w_off;
  assign w_tailer_o     = w_off + w_chunk[OffsetWidth-1:0];
  assign w_shift_o      = w_shift_p0;
  assign w_last_o       = w_vld_p0 & w_last;
  assign w_super_last_o = super_last_p0;
  assign r_busy_o       = r_vld_p0;
  assign w_busy_o       = w_vld_p0;

`ifdef IDMA_LEGALIZER_OBI_RBE_EN
  assign r_be_o = be_mask(r_off, r_chunk);
`else
  assign r_be_o = '1;
`endif

  // Stage p0: read/write machine state and per-transfer options.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p0      <= 1'b0;
      w_vld_p0      <= 1'b0;
      r_addr_p0     <= '0;
      r_len_p0      <= '0;
      w_addr_p0     <= '0;
      w_len_p0      <= '0;
      r_shift_p0    <= '0;
      w_shift_p0    <= '0;
      super_last_p0 <= 1'b0;
    end else if (kill_i) begin
      r_vld_p0  <= 1'b0;
      w_vld_p0  <= 1'b0;
      r_addr_p0 <= '0;
      r_len_p0  <= '0;
      w_addr_p0 <= '0;
      w_len_p0  <= '0;
    end else if (accept) begin
      r_vld_p0      <= (req_length_i != '0);
      w_vld_p0      <= (req_length_i != '0);
      r_addr_p0     <= req_src_addr_i;
      r_len_p0      <= req_length_i;
      w_addr_p0     <= req_dst_addr_i;
      w_len_p0      <= req_length_i;
      super_last_p0 <= req_last_i;
      if (CombinedShifter) begin
        r_shift_p0 <= src_off - dst_off;
        w_shift_p0 <= '0;
      end else begin
        r_shift_p0 <= src_off;
        w_shift_p0 <= -dst_off;
      end
    end else begin
      if (r_fire) begin
        if (r_last) begin
          r_vld_p0 <= 1'b0;
        end else begin
          r_addr_p0 <= r_addr_p0 + r_chunk;
          r_len_p0  <= r_len_p0 - r_chunk;
        end
      end
      if (w_fire) begin
        if (w_last) begin
          w_vld_p0 <= 1'b0;
        end else begin
          w_addr_p0 <= w_addr_p0 + w_chunk;
          w_len_p0  <= w_len_p0 - w_chunk;
        end
      end
    end
  end

endmodule

// File: doc/idma_legalizer_r_obi_w_txrx.md
IDMA_LEGALIZER_R_OBI_W_TXRX -- requirements
Module: idma_legalizer_r_obi_w_txrx

Interface
REQ-001 SHALL have parameter CombinedShifter, default 1'b0, meaning both data shifts are applied in the read shifter.
REQ-002 SHALL have parameter DataWidth, default 32, meaning the bus width in bits; StrbWidth = DataWidth/8 and OffsetWidth = clog2(StrbWidth).
REQ-003 SHALL have parameter AddrWidth, default 32, meaning the address and length width in bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset; all state updates on the rising edge of clk_i.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 req_length_i, req_src_addr_i, req_dst_addr_i  in  AddrWidth each  1D transfer length in bytes, source byte address, destination byte address.
REQ-008 req_last_i  in  1  super-last flag from the midend.
REQ-009 valid_i  in  1 / ready_o  out  1  request handshake.
REQ-010 r_addr_o  out  AddrWidth  word-aligned OBI read address; r_be_o  out  StrbWidth  OBI byte enables.
REQ-011 r_offset_o, r_tailer_o, r_shift_o  out  OffsetWidth each  read datapath setup.
REQ-012 r_valid_o  out  1 / r_ready_i  in  1  read request handshake.
REQ-013 w_offset_o, w_tailer_o, w_shift_o  out  OffsetWidth each  TXRX write datapath setup.
REQ-014 w_last_o, w_super_last_o  out  1 each  last chunk of the 1D transfer / latched req_last_i.
REQ-015 w_valid_o  out  1 / w_ready_i  in  1  write request handshake.
REQ-016 flush_i, kill_i  in  1 each; r_busy_o, w_busy_o  out  1 each.

Function
REQ-017 SHALL hold independent read and write machines, each with state {valid, addr, length}; the read and write machines always run decoupled.
REQ-018 Chunk size per machine SHALL be min(length, StrbWidth - addr[OffsetWidth-1:0]), so every chunk stays within one bus word.
REQ-019 On a read fire (r_valid_o & r_ready_i), addr SHALL advance by the chunk size and length SHALL decrease by it; if length equals the chunk size, valid SHALL clear instead.
REQ-020 The write machine SHALL advance in the same way on w_valid_o & w_ready_i.
REQ-021 w_last_o SHALL be 1 exactly when the presented write chunk equals the remaining write length.
REQ-022 Outputs: r_addr_o = {addr[AddrWidth-1:OffsetWidth], 0}; offset = addr[OffsetWidth-1:0]; tailer = (offset + chunk) mod StrbWidth.
REQ-023 Shifts latched on accept: if CombinedShifter, r_shift = src_off - dst_off and w_shift = 0; otherwise r_shift = src_off and w_shift = -dst_off; all modulo StrbWidth.
REQ-024 r_valid_o = read valid & !flush_i; w_valid_o = write valid & !flush_i; request fields SHALL stay stable while valid is high and not fired.
REQ-025 ready_o = !flush_i & !kill_i & (each machine idle or firing its final chunk this cycle); this gives back-to-back transfers without a bubble.
REQ-026 On accept, both machines SHALL load valid=1, length=req_length_i, and addr = src or dst address respectively; the options (shifts, super_last) SHALL be registered.
REQ-027 A zero-length request SHALL be accepted and emit no read or write chunks (both valids remain 0).
REQ-028 flush_i SHALL freeze all state and deassert r_valid_o, w_valid_o and ready_o.
REQ-029 kill_i SHALL clear both machines in the next cycle regardless of flush_i or fires; no request is accepted in that cycle.
REQ-030 r_busy_o and w_busy_o SHALL equal the respective machine valid bits.

Reset
REQ-031 While rst_i is high at a clock edge, all state SHALL clear; the next cycle shows r_valid_o=w_valid_o=0, busy=0, all fields 0, ready_o=1 (if flush_i and kill_i are low). Reset mid-transfer drops the transfer with no further chunks emitted.

Configuration
REQ-032 Macro IDMA_LEGALIZER_OBI_RBE_EN: when defined, r_be_o sets only the bits [offset, offset+chunk-1]; when undefined, r_be_o is all ones and the datapath discards unused bytes.

Verification (DataWidth=32, CombinedShifter=0, macro defined)
REQ-033 src=0x1002, dst=0x2001, len=7, readies high -> reads: (0x1000, be=1100), (0x1004, 1111), (0x1008, 0001); writes: offsets 1,0, w_last_o on the 2nd; r_shift=2, w_shift=3.
REQ-034 Same transfer with w_ready_i low for 5 cycles -> all reads complete, the write request is held stable, ready_o=0 until the final write fires.
REQ-035 Second request valid during the final chunks of the first -> ready_o=1 in the cycle both last chunks fire, and the new chunk is presented the next cycle.
REQ-036 kill_i pulsed mid-transfer -> busy=0 and valids=0 the next cycle; ready_o=0 during the kill cycle.
REQ-037 flush_i held 3 cycles -> valids low and state unchanged; resumes on the same chunk afterwards.
REQ-038 len=0 request -> accepted, no r_valid_o/w_valid_o pulses; rst_i mid-transfer -> all outputs at reset values.
